// File: rtl/pc_stack_pkg.sv
// Shared defaults and the operation encoding for the program-counter / return-stack unit.
package pc_stack_pkg;

    localparam int PC_W_DEF  = 8;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        OP_NEXT,
        OP_JUMP,
        OP_CALL,
        OP_RET
    } op_e;

endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: DEPTH x W register file with an occupancy counter.
// Only the counter and flags are reset; entry contents persist.
module ras_lifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [DW-1:0] cnt_m1;

    // Push is ignored when full and pop when empty; push wins if both are requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (push && !full) begin
            depth <= depth + DW'(1);
            full  <= (depth == DW'(DEPTH - 1));
            empty <= 1'b0;
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
            full  <= 1'b0;
            empty <= (depth == DW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !full)
            mem[depth[AW-1:0]] <= din;
    end

    assign cnt_m1 = depth - DW'(1);
    assign top    = mem[cnt_m1[AW-1:0]];

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with call/return stack: decodes one of NEXT/JUMP/CALL/RET per
// unstalled cycle and keeps a sticky overflow/underflow error flag.
module pc_stack_unit
    import pc_stack_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    jump,
    input  logic                    ret,
    input  logic                    push,
    input  logic [PC_W-1:0]         target,
    output logic [PC_W-1:0]         pc,
    output logic [$clog2(DEPTH):0]  depth,
    output logic                    stk_full,
    output logic                    stk_empty,
    output logic                    stk_err
);

    op_e              op;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  ras_top;
    logic             do_call;
    logic             do_ret;

    always_comb begin
        op = OP_NEXT;
        if (ret)
            op = OP_RET;
        else if (jump && push)
            op = OP_CALL;
        else if (jump)
            op = OP_JUMP;
    end

    assign pc_inc  = pc + PC_W'(1);
    assign do_call = !stall && (op == OP_CALL);
    assign do_ret  = !stall && (op == OP_RET);

    ras_lifo #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (do_call),
        .pop   (do_ret),
        .din   (pc_inc),
        .top   (ras_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // A failed push or pop still redirects/advances the PC; only the error flag records it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            stk_err <= 1'b0;
        end else if (!stall) begin
            case (op)
                OP_RET: begin
                    pc <= stk_empty ? pc_inc : ras_top;
                    if (stk_empty) stk_err <= 1'b1;
                end
                OP_CALL: begin
                    pc <= target;
                    if (stk_full) stk_err <= 1'b1;
                end
                OP_JUMP: pc <= target;
                default: pc <= pc_inc;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomized and directed bench for pc_stack_unit against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int PC_W  = 8;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall = 1'b0;
    logic            jump = 1'b0;
    logic            ret = 1'b0;
    logic            push = 1'b0;
    logic [PC_W-1:0] target = '0;
    logic [PC_W-1:0] pc;
    logic [3:0]      depth;
    logic            stk_full;
    logic            stk_empty;
    logic            stk_err;

    int tests = 0;
    int fails = 0;

    pc_stack_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jump      (jump),
        .ret       (ret),
        .push      (push),
        .target    (target),
        .pc        (pc),
        .depth     (depth),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err)
    );

    always #5 clk = ~clk;

    // Reference model: PC as an integer, return stack as a queue.
    int         m_pc = 0;
    logic [7:0] m_stk[$];
    bit         m_err = 1'b0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0;
            m_stk.delete();
            m_err = 1'b0;
            m_valid = 1'b1;
        end else if (!stall) begin
            if (ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = (m_pc + 1) % 256; m_err = 1'b1; end
            end else if (jump && push) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(8'((m_pc + 1) % 256));
                else m_err = 1'b1;
                m_pc = target;
            end else if (jump) begin
                m_pc = target;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc", 32'(pc), 32'(m_pc));
            chk("model_depth", 32'(depth), 32'(m_stk.size()));
            chk("model_full", 32'(stk_full), 32'(m_stk.size() == DEPTH));
            chk("model_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
            chk("model_err", 32'(stk_err), 32'(m_err));
        end
    end

    task automatic tick(input logic r, input logic s, input logic j, input logic rt,
                        input logic p, input logic [7:0] t);
        rst = r; stall = s; jump = j; ret = rt; push = p; target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        // Reset and free-running count
        tick(1, 0, 0, 0, 0, 8'h00);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_empty", 32'(stk_empty), 32'h1);
        chk("rst_full", 32'(stk_full), 32'h0);
        chk("rst_err", 32'(stk_err), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("idle_pc", 32'(pc), 32'(i));
        end
        chk("idle_model_pc", 32'(m_pc), 32'h4);

        // Single call / return
        tick(0, 0, 1, 0, 0, 8'h10);
        tick(0, 0, 1, 0, 1, 8'h40);
        chk("call_pc", 32'(pc), 32'h40);
        chk("call_depth", 32'(depth), 32'h1);
        idle(); idle();
        tick(0, 0, 0, 1, 0, 8'h00);
        chk("ret_pc", 32'(pc), 32'h11);
        chk("ret_depth", 32'(depth), 32'h0);
        chk("ret_model_pc", 32'(m_pc), 32'h11);

        // Wraparound
        tick(0, 0, 1, 0, 0, 8'hFF);
        idle();
        chk("wrap_pc", 32'(pc), 32'h00);
        tick(0, 0, 1, 0, 0, 8'hFF);
        tick(0, 0, 1, 0, 1, 8'h30);
        chk("wrap_call_pc", 32'(pc), 32'h30);
        tick(0, 0, 0, 1, 0, 8'h00);
        chk("wrap_ret_pc", 32'(pc), 32'h00);

        // Stall and RET priority
        tick(0, 0, 1, 0, 0, 8'h20);
        tick(0, 1, 1, 0, 0, 8'h55);
        chk("stall_pc", 32'(pc), 32'h20);
        tick(0, 0, 1, 0, 1, 8'h60);
        tick(0, 1, 0, 1, 0, 8'h00);
        chk("stall_ret_depth", 32'(depth), 32'h1);
        tick(0, 0, 1, 1, 1, 8'h77);
        chk("retprio_pc", 32'(pc), 32'h21);
        chk("retprio_depth", 32'(depth), 32'h0);
        chk("retprio_err", 32'(stk_err), 32'h0);
        tick(0, 0, 0, 0, 1, 8'h99);
        chk("pushonly_pc", 32'(pc), 32'h22);
        chk("pushonly_depth", 32'(depth), 32'h0);

        // Fill, overflow, drain in LIFO order
        tick(1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, 1, 8'(8'h10 + i));
        chk("fill_full", 32'(stk_full), 32'h1);
        chk("fill_depth", 32'(depth), 32'h8);
        tick(0, 0, 1, 0, 1, 8'h80);
        chk("ovf_pc", 32'(pc), 32'h80);
        chk("ovf_depth", 32'(depth), 32'h8);
        chk("ovf_err", 32'(stk_err), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, 0, 1, 0, 8'h00);
            chk("drain_pc", 32'(pc), (k < 7) ? 32'(8'h17 - k) : 32'h01);
        end
        chk("drain_empty", 32'(stk_empty), 32'h1);

        // Underflow; error sticky until reset
        tick(1, 0, 0, 0, 0, 8'h00);
        tick(0, 0, 1, 0, 0, 8'h22);
        tick(0, 0, 0, 1, 0, 8'h00);
        chk("unf_pc", 32'(pc), 32'h23);
        chk("unf_err", 32'(stk_err), 32'h1);
        chk("unf_depth", 32'(depth), 32'h0);
        tick(0, 0, 1, 0, 1, 8'h05);
        tick(0, 0, 0, 1, 0, 8'h00);
        idle();
        chk("unf_sticky", 32'(stk_err), 32'h1);

        // Reset mid-sequence discards stacked entries
        tick(0, 0, 1, 0, 1, 8'h44);
        tick(0, 0, 1, 0, 1, 8'h48);
        tick(1, 1, 1, 0, 1, 8'h50);
        chk("midrst_pc", 32'(pc), 32'h0);
        chk("midrst_depth", 32'(depth), 32'h0);
        chk("midrst_err", 32'(stk_err), 32'h0);
        idle();
        chk("midrst_next", 32'(pc), 32'h1);

        // Randomized traffic; the compare process checks every cycle
        for (int n = 0; n < 3000; n++) begin
            logic r, s, j, rt, p;
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 2) == 0);
            rt = ($urandom_range(0, 4) == 0);
            p  = ($urandom_range(0, 1) == 0);
            tick(r, s, j, rt, p, 8'($urandom));
        end

        idle();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
